// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_pkg: shared types and helpers for the scoreboarded       |
// | multi-port register file.            Revision: 1.0               |
// +------------------------------------------------------------------+
package regfile_pkg;

  localparam int c_data_w = 32;
  localparam int c_nregs  = 32;
  localparam int c_addr_w = $clog2(c_nregs);

  typedef logic [c_addr_w-1:0] reg_addr_t;
  typedef logic [c_data_w-1:0] reg_data_t;

  typedef enum logic [0:0] {
    SB_IDLE    = 1'b0,
    SB_PENDING = 1'b1
  } sb_state_e;

  function automatic logic is_zero_reg(input logic [31:0] addr, input logic zero_en,
                                       input int zero_reg);
    return zero_en && (addr == 32'(zero_reg));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rf_scoreboard: per-register pending bits, issue handshake and    |
// | sticky unexpected-write-back flag.   Revision: 1.0               |
// +------------------------------------------------------------------+
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int N        = 32,
  parameter int NRD      = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_pend,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  output logic              err_unexp_wb
);

  sb_state_e    r_state [N];
  logic [N-1:0] w_pend;
  logic         w_iss_zero;
  logic         w_wb_zero;
  logic         w_ready_core;
  logic         w_xfer;
  logic         w_unexp;
  logic         r_err;

  always_comb begin
    w_pend = '0;
    for (int j = 0; j < N; j++) begin
      w_pend[j] = (r_state[j] == SB_PENDING);
    end
  end

  assign w_iss_zero = is_zero_reg(32'(iss_addr), ZERO_EN != 0, ZERO_REG);
  assign w_wb_zero  = is_zero_reg(32'(wb_addr), ZERO_EN != 0, ZERO_REG);

  // Ready ignores rst so the async reset never feeds a flop's data path.
  assign w_ready_core = w_iss_zero || !w_pend[iss_addr] ||
                        (wb_valid && (wb_addr == iss_addr));
  assign w_xfer       = iss_valid && w_ready_core && !w_iss_zero;
  assign iss_ready    = !rst && w_ready_core;
  assign w_unexp      = wb_valid && !w_wb_zero && !w_pend[wb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        r_state[j] <= SB_IDLE;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        case (r_state[j])
          SB_IDLE: begin
            if (w_xfer && (iss_addr == AW'(j))) begin
              r_state[j] <= SB_PENDING;
            end
          end
          SB_PENDING: begin
            // A same-cycle reservation of this register outranks its write-back.
            if (wb_valid && (wb_addr == AW'(j)) && !(w_xfer && (iss_addr == AW'(j)))) begin
              r_state[j] <= SB_IDLE;
            end
          end
          default: r_state[j] <= SB_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_unexp) begin
      r_err <= 1'b1;
    end
  end

  assign err_unexp_wb = r_err;

  for (genvar i = 0; i < NRD; i++) begin : g_pend
    assign rd_pend[i] = w_pend[rd_addr[i*AW +: AW]];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_mp_sb: multi-read-port register file with write-back     |
// | bypass, zero register and scoreboard. Revision: 1.0              |
// +------------------------------------------------------------------+
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int W        = 32,
  parameter int N        = 32,
  parameter int NRD      = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [W-1:0]      wb_data,
  output logic              err_unexp_wb
);

  logic [W-1:0]   r_regs [N];
  logic [NRD-1:0] w_pend_rd;
  logic           w_wb_zero;

  rf_scoreboard #(
    .N        (N),
    .NRD      (NRD),
    .ZERO_EN  (ZERO_EN),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .rd_addr      (rd_addr),
    .rd_pend      (w_pend_rd),
    .iss_valid    (iss_valid),
    .iss_addr     (iss_addr),
    .iss_ready    (iss_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .err_unexp_wb (err_unexp_wb)
  );

  assign w_wb_zero = is_zero_reg(32'(wb_addr), ZERO_EN != 0, ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_regs[k] <= '0;
      end
    end else if (wb_valid && !w_wb_zero) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_zero;
    logic          w_hit;

    assign w_addr = rd_addr[i*AW +: AW];
    assign w_zero = is_zero_reg(32'(w_addr), ZERO_EN != 0, ZERO_REG);
    assign w_hit  = (BYPASS != 0) && wb_valid && (wb_addr == w_addr);

    // Zero-register masking takes priority over the bypass path.
    assign rd_data[i*W +: W] = (rst || w_zero) ? '0 : (w_hit ? wb_data : r_regs[w_addr]);
    assign rd_busy[i]        = !rst && !w_zero && !w_hit && w_pend_rd[i];
  end

endmodule
`default_nettype wire
